// File: rtl/vt52_pkg.sv
// Shared constants, state encoding and coordinate helpers for the VT52 character writer.
// The optional erase commands (ESC J / ESC K) are compiled in with VT52_ERASE_EN.
package vt52_pkg;

  localparam int unsigned COLS   = 80;
  localparam int unsigned ROWS   = 24;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned X_W    = 7;
  localparam int unsigned Y_W    = 5;

  localparam logic [7:0] CH_ESC   = 8'h1B;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_SPACE = 8'h20;

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);

  typedef enum logic [2:0] {
    NORMAL,
    ESC,
    ESC_Y_ROW,
    ESC_Y_COL,
    ERASE
  } state_t;

  // Row-major cell address; y*80 expressed as shifts so no multiplier is built.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [X_W-1:0] x,
                                                  input logic [Y_W-1:0] y);
    return (ADDR_W'(y) << 6) + (ADDR_W'(y) << 4) + ADDR_W'(x);
  endfunction

  // Direct-cursor-address coordinate: byte minus 32, floored at 0 and capped at lim.
  function automatic logic [7:0] coord_clamp(input logic [7:0] b, input logic [7:0] lim);
    logic [7:0] off;
    off = b - 8'h20;
    if (b < 8'h20) return 8'd0;
    if (off > lim) return lim;
    return off;
  endfunction

endpackage

// File: rtl/vt52_char_writer_if.sv
// Byte-stream input handshake plus character-buffer write port of the VT52 writer.
interface vt52_char_writer_if;
  import vt52_pkg::*;

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_din;
  logic              buf_wen;

  // master: byte source and buffer observer; slave: the character writer
  modport master (
    output in_data, in_valid,
    input  in_ready, buf_addr, buf_din, buf_wen
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, buf_addr, buf_din, buf_wen
  );

endinterface

// File: rtl/vt52_erase_seq.sv
// Address sequencer for erase runs: steps one address per cycle from start to end.
// The first address is written by the caller; this block supplies each following one.
module vt52_erase_seq
  import vt52_pkg::*;
(
  input  logic              pclk,
  input  logic              clr,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] wr_addr_c,
  output logic              wr_en_c,
  output logic              done_c
);

  logic              active;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] end_q;

  // addr tracks the address currently presented on the buffer port
  always_ff @(posedge pclk or negedge clr) begin
    if (!clr) begin
      active <= 1'b0;
      addr   <= '0;
      end_q  <= '0;
    end else if (start) begin
      active <= 1'b1;
      addr   <= start_addr;
      end_q  <= end_addr;
    end else if (active) begin
      if (addr == end_q) begin
        active <= 1'b0;
      end else begin
        addr <= addr + ADDR_W'(1);
      end
    end
  end

  assign wr_addr_c = addr + ADDR_W'(1);
  assign wr_en_c   = active && (addr != end_q);
  assign done_c    = active && (addr == end_q);

endmodule

// File: rtl/vt52_char_writer.sv
// VT52 byte-stream decoder driving single-byte character-buffer writes and the cursor.
// Define VT52_ERASE_EN to add ESC J / ESC K erase support and the busy indication.
module vt52_char_writer
  import vt52_pkg::*;
(
  input  logic               pclk,
  input  logic               clr,
  vt52_char_writer_if.slave  bus,
  output logic [X_W-1:0]     cursor_x,
  output logic [Y_W-1:0]     cursor_y,
  output logic               busy
);

  state_t            state, state_n;
  logic [X_W-1:0]    x_n;
  logic [Y_W-1:0]    y_n;
  logic              wen_n;
  logic [ADDR_W-1:0] addr_n;
  logic [7:0]        din_n;
  logic [7:0]        d;
  logic              accept_c;
  logic [ADDR_W-1:0] cur_addr_c;
  logic [7:0]        tab_c;
  logic [X_W-1:0]    x_inc_c, x_dec_c;
  logic [Y_W-1:0]    y_inc_c, y_dec_c;

`ifdef VT52_ERASE_EN
  logic              erase_start;
  logic [ADDR_W-1:0] erase_end;
  logic [ADDR_W-1:0] seq_addr_c;
  logic              seq_wen_c;
  logic              seq_done_c;

  vt52_erase_seq u_erase_seq (
    .pclk       (pclk),
    .clr        (clr),
    .start      (erase_start),
    .start_addr (cur_addr_c),
    .end_addr   (erase_end),
    .wr_addr_c  (seq_addr_c),
    .wr_en_c    (seq_wen_c),
    .done_c     (seq_done_c)
  );

  assign bus.in_ready = (state != ERASE);
`else
  assign bus.in_ready = 1'b1;
`endif

  assign d          = bus.in_data;
  assign accept_c   = bus.in_valid && bus.in_ready;
  assign cur_addr_c = cell_addr(cursor_x, cursor_y);

  // Saturating cursor moves; the screen neither wraps nor scrolls
  assign x_inc_c = (cursor_x == X_W'(COLS - 1)) ? cursor_x : cursor_x + X_W'(1);
  assign x_dec_c = (cursor_x == '0) ? cursor_x : cursor_x - X_W'(1);
  assign y_inc_c = (cursor_y == Y_W'(ROWS - 1)) ? cursor_y : cursor_y + Y_W'(1);
  assign y_dec_c = (cursor_y == '0) ? cursor_y : cursor_y - Y_W'(1);
  assign tab_c   = {1'b0, cursor_x | X_W'(7)} + 8'd1;

  always_ff @(posedge pclk or negedge clr) begin
    if (!clr) begin
      state        <= NORMAL;
      cursor_x     <= '0;
      cursor_y     <= '0;
      bus.buf_wen  <= 1'b0;
      bus.buf_addr <= '0;
      bus.buf_din  <= '0;
    end else begin
      state        <= state_n;
      cursor_x     <= x_n;
      cursor_y     <= y_n;
      bus.buf_wen  <= wen_n;
      bus.buf_addr <= addr_n;
      bus.buf_din  <= din_n;
    end
  end

`ifdef VT52_ERASE_EN
  always_ff @(posedge pclk or negedge clr) begin
    if (!clr) busy <= 1'b0;
    else      busy <= (state_n == ERASE);
  end
`else
  assign busy = 1'b0;
`endif

  always_comb begin
    state_n = state;
    x_n     = cursor_x;
    y_n     = cursor_y;
    wen_n   = 1'b0;
    addr_n  = bus.buf_addr;
    din_n   = bus.buf_din;
`ifdef VT52_ERASE_EN
    erase_start = 1'b0;
    erase_end   = cur_addr_c;
`endif

    case (state)
      NORMAL: begin
        if (accept_c) begin
          if (d >= 8'h20 && d <= 8'h7E) begin
            wen_n  = 1'b1;
            addr_n = cur_addr_c;
            din_n  = d;
            x_n    = x_inc_c;
          end else begin
            case (d)
              CH_CR:   x_n = '0;
              CH_LF:   y_n = y_inc_c;
              CH_BS:   x_n = x_dec_c;
              CH_TAB:  x_n = (tab_c > 8'(COLS - 1)) ? X_W'(COLS - 1) : tab_c[X_W-1:0];
              CH_ESC:  state_n = ESC;
              default: ;
            endcase
          end
        end
      end

      ESC: begin
        if (accept_c) begin
          state_n = NORMAL;
          case (d)
            8'h41: y_n = y_dec_c;
            8'h42: y_n = y_inc_c;
            8'h43: x_n = x_inc_c;
            8'h44: x_n = x_dec_c;
            8'h48: begin
              x_n = '0;
              y_n = '0;
            end
            8'h59: state_n = ESC_Y_ROW;
`ifdef VT52_ERASE_EN
            // First space goes out with the command; the sequencer supplies the rest
            8'h4A, 8'h4B: begin
              state_n     = ERASE;
              erase_start = 1'b1;
              erase_end   = (d == 8'h4A) ? LAST_CELL : cell_addr(X_W'(COLS - 1), cursor_y);
              wen_n       = 1'b1;
              addr_n      = cur_addr_c;
              din_n       = CH_SPACE;
            end
`endif
            default: ;
          endcase
        end
      end

      ESC_Y_ROW: begin
        if (accept_c) begin
          y_n     = Y_W'(coord_clamp(d, 8'(ROWS - 1)));
          state_n = ESC_Y_COL;
        end
      end

      ESC_Y_COL: begin
        if (accept_c) begin
          x_n     = X_W'(coord_clamp(d, 8'(COLS - 1)));
          state_n = NORMAL;
        end
      end

`ifdef VT52_ERASE_EN
      ERASE: begin
        if (seq_done_c) begin
          state_n = NORMAL;
        end else begin
          wen_n  = seq_wen_c;
          addr_n = seq_addr_c;
          din_n  = CH_SPACE;
        end
      end
`endif

      default: state_n = NORMAL;
    endcase
  end

endmodule
